// File: rtl/piradspi_arb_pkg.sv
// Shared types and helpers for the packet arbiter and its round-robin picker.
package piradspi_arb_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    // Index width that stays at least 1 bit even for a 2-entry (or smaller) range.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piradspi_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
// Zero latency; no backpressure (pure function of req and last).
module piradspi_rr_pick
    import piradspi_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    localparam int IW   = clog2_min1(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    gnt_idx,
    output logic             any_req
);

    logic [2*N_SRC-1:0] dbl;
    logic               found;

    // Scanning a doubled copy of req upward from last+1 gives wrap-around for free.
    always_comb begin
        dbl     = {req, req};
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!found && dbl[int'(last) + k]) begin
                found   = 1'b1;
                gnt_idx = IW'((int'(last) + k) % N_SRC);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/piradspi_axis_pkt_arbiter.sv
// Packet-granular round-robin AXIS arbiter; 1-cycle arbitration, grant held through tlast.
// Backpressure: m_tready passes straight to the granted s_tready; optional idle-beat release under PIRADSPI_ARB_TIMEOUT_EN.
module piradspi_axis_pkt_arbiter
    import piradspi_arb_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int N_SRC          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = clog2_min1(N_SRC)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [N_SRC*WIDTH-1:0] s_tdata,
    input  logic [N_SRC-1:0]       s_tvalid,
    input  logic [N_SRC-1:0]       s_tlast,
    output logic [N_SRC-1:0]       s_tready,
    output logic [WIDTH-1:0]       m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [IW-1:0]          grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    if (N_SRC < 2 || N_SRC > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("piradspi_axis_pkt_arbiter: illegal N_SRC or TIMEOUT_CYCLES");
    end

    arb_state_t    state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] pick_idx;
    logic          any_req;
    logic          beat;

    piradspi_rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req     (s_tvalid),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    // Datapath is a plain mux; nothing from a non-granted source reaches m_*.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state == XFER) begin
            m_tdata            = s_tdata[int'(grant_id)*WIDTH +: WIDTH];
            m_tvalid           = s_tvalid[grant_id];
            m_tlast            = s_tlast[grant_id];
            s_tready[grant_id] = m_tready;
        end
    end

    assign beat = m_tvalid & m_tready;
    assign busy = (state == XFER);

`ifdef PIRADSPI_ARB_TIMEOUT_EN
    localparam int CW = clog2_min1(TIMEOUT_CYCLES);
    logic [CW-1:0] stall_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(N_SRC - 1);
`ifdef PIRADSPI_ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef PIRADSPI_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef PIRADSPI_ARB_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    if (any_req) begin
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (beat && m_tlast) begin
                        state <= IDLE;
                    end
`ifdef PIRADSPI_ARB_TIMEOUT_EN
                    // Forced release without a fake tlast; the pointer already
                    // points at this source, so it naturally drops to last priority.
                    if (beat) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        stall_cnt   <= '0;
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piradspi_axis_pkt_arbiter.sv
// Randomised bench for the packet arbiter with a packet-level round-robin scoreboard.
module tb_piradspi_axis_pkt_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int IW = 2;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [N*W-1:0]   s_tdata;
    logic [N-1:0]     s_tvalid, s_tlast, s_tready;
    logic [W-1:0]     m_tdata;
    logic             m_tvalid, m_tlast, m_tready;
    logic [IW-1:0]    grant_id;
    logic             busy, timeout_err;

    piradspi_axis_pkt_arbiter #(.WIDTH(W), .N_SRC(N), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {logic [W-1:0] d; logic l;} beat_t;

    beat_t        drv_q [N][$];
    beat_t        exp_q [N][$];
    int           n_chk = 0, n_pass = 0;
    logic [N-1:0] hold, force_low, rdy_smp, prev_vld;
    bit           prev_busy, expect_idle, exp_to;
    int           exp_last, cur, stall, p_vld, p_rdy, rdy_mode, pat_idx;
    int           to_pulses, beats_seen, total_beats;
    int           beats_src [N];
    int           grants[$];
    bit           mv_log[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Reference pick: first requester after the previous grantee, modulo N.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    task automatic add_pkt(input int s, input int len);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.d = $urandom;
            x.l = (b == len - 1);
            drv_q[s].push_back(x);
            exp_q[s].push_back(x);
        end
        total_beats += len;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && drv_q[i].size() > 0 && $urandom_range(99) < p_vld) hold[i] = 1'b1;
            s_tvalid[i] = hold[i] && !force_low[i];
            if (hold[i]) begin
                s_tdata[i*W +: W] = drv_q[i][0].d;
                s_tlast[i]        = drv_q[i][0].l;
            end else begin
                s_tdata[i*W +: W] = $urandom;
                s_tlast[i]        = 1'($urandom_range(1));
            end
        end
        if (rdy_mode == 1) begin
            m_tready = (pat_idx % 3 == 0);
            pat_idx++;
        end else begin
            m_tready = ($urandom_range(99) < p_rdy);
        end
    endtask

    task automatic monitor();
        logic [N-1:0] oh;
        beat_t        e;
        int           g;
        rdy_smp = s_tready;
        if (!aresetn) begin
            prev_busy = 1'b0;
            prev_vld  = '0;
            return;
        end
        mv_log.push_back(m_tvalid);
        if (timeout_err) to_pulses++;
`ifdef PIRADSPI_ARB_TIMEOUT_EN
        check("timeout_err", timeout_err, exp_to);
        exp_to = 1'b0;
`else
        check("timeout_err", timeout_err, 0);
`endif
        if (expect_idle) begin
            check("release", busy, 0);
            expect_idle = 1'b0;
        end else if (!prev_busy && prev_vld != '0) begin
            check("arb_latency", busy, 1);
        end
        if (busy && !prev_busy) begin
            g = rr_pick(prev_vld, exp_last);
            check("grant_id", grant_id, g);
            cur = (g < 0) ? int'(grant_id) : g;
            exp_last = cur;
            grants.push_back(cur);
            stall = 0;
        end
        if (busy) begin
            oh = '0;
            if (m_tready) oh[cur] = 1'b1;
            check("grant_hold", grant_id, cur);
            check("s_tready", s_tready, oh);
            check("m_tvalid", m_tvalid, s_tvalid[cur]);
            if (m_tvalid && m_tready) begin
                check("beat_avail", exp_q[cur].size() > 0, 1);
                if (exp_q[cur].size() > 0) begin
                    e = exp_q[cur].pop_front();
                    check("m_tdata", m_tdata, e.d);
                    check("m_tlast", m_tlast, e.l);
                    if (e.l) expect_idle = 1'b1;
                end
                beats_seen++;
                beats_src[cur]++;
                stall = 0;
            end else begin
`ifdef PIRADSPI_ARB_TIMEOUT_EN
                stall++;
                if (stall == TO) begin
                    expect_idle = 1'b1;
                    exp_to      = 1'b1;
                    stall       = 0;
                end
`endif
            end
        end else begin
            check("idle_s_tready", s_tready, 0);
            check("idle_m_tvalid", m_tvalid, 0);
        end
        prev_busy = busy;
        prev_vld  = s_tvalid;
    endtask

    task automatic cycle();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hold[i] && !force_low[i] && rdy_smp[i]) begin
                void'(drv_q[i].pop_front());
                hold[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic reset_assert();
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            beats_src[i] = 0;
        end
        hold = '0; force_low = '0; prev_vld = '0;
        grants.delete(); mv_log.delete();
        exp_last = N - 1; cur = 0; stall = 0;
        prev_busy = 0; expect_idle = 0; exp_to = 0;
        beats_seen = 0; total_beats = 0; to_pulses = 0;
        pat_idx = 0; rdy_mode = 0; p_vld = 100; p_rdy = 100;
    endtask

    task automatic reset_release();
        drive();
        repeat (2) cycle();
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_grant_id", grant_id, 0);
        aresetn = 1'b1;
    endtask

    task automatic run(input int budget, output int n);
        n = 0;
        while (pending() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drained", pending(), 0);
        repeat (2) cycle();
    endtask

    initial begin : main
        int n;
        int ord[6];
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;

        // Reset with every source requesting: source 0 first, valid in 2nd cycle.
        reset_assert();
        for (int i = 0; i < N; i++) add_pkt(i, 2);
        reset_release();
        run(200, n);
        check("t1_mvalid_c1", mv_log[0], 0);
        check("t1_mvalid_c2", mv_log[1], 1);
        check("t1_first_grant", grants[0], 0);
        check("t1_grants", grants.size(), 4);

        // Three continuous 3-beat streams: strict order 0,1,3 and 4 cycles per packet.
        reset_assert();
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 3); add_pkt(1, 3); add_pkt(3, 3);
        end
        reset_release();
        run(200, n);
        check("t2_cycles", n, 24);
        ord = '{0, 1, 3, 0, 1, 3};
        check("t2_ngrants", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++) check("t2_order", grants[i], ord[i]);

        // Ready toggling 1,0,0 on a 4-beat packet from source 2.
        reset_assert();
        rdy_mode = 1;
        add_pkt(2, 4);
        reset_release();
        run(200, n);
        check("t3_beats", beats_src[2], 4);
        check("t3_ngrants", grants.size(), 1);

        // Single requester, single-beat packets: valid alternates 0,1.
        reset_assert();
        for (int i = 0; i < 5; i++) add_pkt(1, 1);
        reset_release();
        run(200, n);
        check("t4_cycles", n, 10);
        for (int i = 0; i < 10; i++) check("t4_mvalid", mv_log[i], i % 2);
        check("t4_ngrants", grants.size(), 5);
        for (int i = 0; i < grants.size(); i++) check("t4_grant", grants[i], 1);

        // Asynchronous reset in the middle of a 5-beat packet.
        reset_assert();
        add_pkt(0, 5); add_pkt(1, 2); add_pkt(3, 2);
        reset_release();
        n = 0;
        while (beats_src[0] < 1 && n < 50) begin cycle(); n++; end
        check("t5_pre_busy", busy, 1);
        #2 aresetn = 1'b0;
        #1;
        check("t5_s_tready", s_tready, 0);
        check("t5_m_tvalid", m_tvalid, 0);
        check("t5_busy", busy, 0);
        reset_assert();
        add_pkt(2, 2); add_pkt(1, 1); add_pkt(0, 2);
        reset_release();
        run(200, n);
        check("t5_restart", grants[0], 0);

        // Granted source drops valid mid-packet.
        reset_assert();
        add_pkt(0, 3); add_pkt(1, 1);
        reset_release();
        n = 0;
        while (beats_src[0] < 1 && n < 50) begin cycle(); n++; end
        force_low[0] = 1'b1;
        drive();
`ifdef PIRADSPI_ARB_TIMEOUT_EN
        repeat (20) cycle();
        check("t6_pulses", to_pulses, 1);
        check("t6_ngrants", grants.size(), 2);
        if (grants.size() >= 2) check("t6_next", grants[1], 1);
`else
        repeat (120) cycle();
        check("t6_busy", busy, 1);
        check("t6_grant", grant_id, 0);
        check("t6_pulses", to_pulses, 0);
        check("t6_ngrants", grants.size(), 1);
`endif
        force_low = '0;
        drive();
        run(200, n);
        check("t6_src0_beats", beats_src[0], 3);

        // Random traffic from all sources with random valid/ready gaps.
        reset_assert();
        p_vld = 70; p_rdy = 60;
        for (int k = 0; k < 40; k++) add_pkt($urandom_range(N - 1), $urandom_range(1, 5));
        reset_release();
        p_vld = 70; p_rdy = 60;
        run(6000, n);
        check("t7_beats", beats_seen, total_beats);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
